// File: rtl/tile_dispatcher_if.sv
// Pixel/decision inputs plus the two tile output streams of tile_dispatcher.
// slave is the dispatcher's view; master is the view of whoever drives it.
interface tile_dispatcher_if #(
    parameter int PIX_W = 8
);
    logic [PIX_W-1:0] iData;
    logic             iValid;
    logic             iRouteToCnn;
    logic             iDecisionValid;

    logic [PIX_W-1:0] oCnnData;
    logic             oCnnValid;
    logic             oCnnLast;
    logic             iCnnReady;

    logic [PIX_W-1:0] oSnnData;
    logic             oSnnValid;
    logic             oSnnLast;
    logic             iSnnReady;

    modport slave (
        input  iData, iValid, iRouteToCnn, iDecisionValid, iCnnReady, iSnnReady,
        output oCnnData, oCnnValid, oCnnLast, oSnnData, oSnnValid, oSnnLast
    );

    modport master (
        output iData, iValid, iRouteToCnn, iDecisionValid, iCnnReady, iSnnReady,
        input  oCnnData, oCnnValid, oCnnLast, oSnnData, oSnnValid, oSnnLast
    );
endinterface

// File: rtl/tile_dispatcher.sv
// Two-bank tile buffer: routes each completed tile to the CNN or SNN stream once decided; first beat 2 cycles after the decision when idle.
// Output stalls on the selected sink's ready; the pixel input is never backpressured, so tiles with no free bank are dropped.
module tile_dispatcher #(
    parameter int TILE_WIDTH = 16,
    parameter int PIX_W      = 8,
    parameter int CNT_W      = 16
) (
    input  logic             iClk,
    input  logic             iRst,
    tile_dispatcher_if.slave bus,
    output logic [CNT_W-1:0] oCnnTiles,
    output logic [CNT_W-1:0] oSnnTiles,
    output logic             oOverflow,
    output logic             oProtoErr
);
    localparam int TILE_PIX = TILE_WIDTH * TILE_WIDTH;
    localparam int IDX_W    = $clog2(TILE_PIX);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TILE_PIX - 1);

    typedef enum logic [2:0] {B_FREE, B_FILLING, B_PENDING, B_READY, B_DRAINING} bank_st_t;
    typedef enum logic [1:0] {RD_IDLE, RD_PRIME, RD_STREAM} rd_st_t;

    logic [PIX_W-1:0] r_mem [2][TILE_PIX];
    bank_st_t         r_bank_st    [2];
    logic             r_bank_route [2];

    logic [IDX_W-1:0] r_wr_idx;
    logic             r_wr_bank;
    logic             r_wr_drop;

    // Completed tiles awaiting a decision, oldest first; phantom entries stand for dropped tiles.
    logic             r_pq_ph   [3];
    logic             r_pq_bank [3];
    logic [1:0]       r_pq_cnt;

    // Decided banks in drain order.
    logic             r_dq_bank [2];
    logic [1:0]       r_dq_cnt;

    rd_st_t           r_rd_st;
    rd_st_t           w_rd_nxt;
    logic [IDX_W-1:0] r_beat;
    logic [PIX_W-1:0] r_rd_dat;
    logic             r_rd_route;
    logic [CNT_W-1:0] r_cnn_cnt;
    logic [CNT_W-1:0] r_snn_cnt;
    logic             r_ovf;
    logic             r_proto;

    logic             w_out_vld;
    logic             w_out_rdy;
    logic             w_hs;
    logic             w_last;
    logic             w_done;
    logic             w_drain_bank;
    logic [1:0]       w_free;
    logic             w_px0;
    logic             w_pxl;
    logic             w_claim_ok;
    logic             w_claim_bank;
    logic             w_cur_drop;
    logic             w_cur_bank;
    logic             w_wr_en;
    logic             w_pq_pop;
    logic             w_pq_push;
    logic [1:0]       w_pq_widx;
    logic             w_dec_real;
    logic             w_dec_bank;
    logic             w_dq_widx;
    logic [IDX_W-1:0] w_beat_nxt;

    assign w_out_vld    = (r_rd_st == RD_STREAM);
    assign w_out_rdy    = r_rd_route ? bus.iCnnReady : bus.iSnnReady;
    assign w_hs         = w_out_vld && w_out_rdy;
    assign w_last       = (r_beat == LAST_IDX);
    assign w_done       = w_hs && w_last;
    assign w_drain_bank = r_dq_bank[0];
    assign w_beat_nxt   = r_beat + 1'b1;

    // A bank released by this cycle's final beat can already take a new tile.
    assign w_free[0]    = (r_bank_st[0] == B_FREE) || (w_done && !w_drain_bank);
    assign w_free[1]    = (r_bank_st[1] == B_FREE) || (w_done && w_drain_bank);

    assign w_px0        = bus.iValid && (r_wr_idx == '0);
    assign w_pxl        = bus.iValid && (r_wr_idx == LAST_IDX);
    assign w_claim_ok   = w_free[0] || w_free[1];
    assign w_claim_bank = !w_free[0];
    assign w_cur_drop   = w_px0 ? !w_claim_ok : r_wr_drop;
    assign w_cur_bank   = w_px0 ? w_claim_bank : r_wr_bank;
    assign w_wr_en      = bus.iValid && !w_cur_drop;

    assign w_pq_pop     = bus.iDecisionValid && (r_pq_cnt != 2'd0);
    assign w_pq_push    = w_pxl && ((r_pq_cnt != 2'd3) || w_pq_pop);
    assign w_pq_widx    = r_pq_cnt - {1'b0, w_pq_pop};
    assign w_dec_real   = w_pq_pop && !r_pq_ph[0];
    assign w_dec_bank   = r_pq_bank[0];
    assign w_dq_widx    = r_dq_cnt[0] && !w_done;

    always_ff @(posedge iClk) begin
        if (!iRst) begin
            r_rd_st <= RD_IDLE;
        end else begin
            r_rd_st <= w_rd_nxt;
        end
    end

    always_comb begin
        w_rd_nxt = r_rd_st;
        case (r_rd_st)
            RD_IDLE:   if (r_dq_cnt != 2'd0) w_rd_nxt = RD_PRIME;
            RD_PRIME:  w_rd_nxt = RD_STREAM;
            RD_STREAM: if (w_done) w_rd_nxt = (r_dq_cnt > 2'd1) ? RD_PRIME : RD_IDLE;
            default:   w_rd_nxt = RD_IDLE;
        endcase
    end

    always_ff @(posedge iClk) begin
        if (iRst && w_wr_en) begin
            r_mem[w_cur_bank][r_wr_idx] <= bus.iData;
        end
    end

    always_ff @(posedge iClk) begin
        if (!iRst) begin
            r_wr_idx   <= '0;
            r_wr_bank  <= 1'b0;
            r_wr_drop  <= 1'b0;
            r_pq_cnt   <= '0;
            r_dq_cnt   <= '0;
            r_beat     <= '0;
            r_rd_dat   <= '0;
            r_rd_route <= 1'b0;
            r_cnn_cnt  <= '0;
            r_snn_cnt  <= '0;
            r_ovf      <= 1'b0;
            r_proto    <= 1'b0;
            for (int b = 0; b < 2; b++) begin
                r_bank_st[b]    <= B_FREE;
                r_bank_route[b] <= 1'b0;
                r_dq_bank[b]    <= 1'b0;
            end
            for (int e = 0; e < 3; e++) begin
                r_pq_ph[e]   <= 1'b0;
                r_pq_bank[e] <= 1'b0;
            end
        end else begin
            if (bus.iValid) begin
                r_wr_idx <= w_pxl ? '0 : r_wr_idx + 1'b1;
            end
            if (w_px0) begin
                r_wr_bank <= w_claim_bank;
                r_wr_drop <= !w_claim_ok;
            end
            if (w_px0 && !w_claim_ok) r_ovf <= 1'b1;
            if (bus.iDecisionValid && (r_pq_cnt == 2'd0)) r_proto <= 1'b1;

            // Later assignments win: a bank freed and reclaimed in one cycle ends up FILLING.
            if (r_rd_st == RD_PRIME) r_bank_st[w_drain_bank] <= B_DRAINING;
            if (w_done) r_bank_st[w_drain_bank] <= B_FREE;
            if (w_dec_real) begin
                r_bank_st[w_dec_bank]    <= B_READY;
                r_bank_route[w_dec_bank] <= bus.iRouteToCnn;
            end
            if (w_wr_en && w_px0) r_bank_st[w_cur_bank] <= B_FILLING;
            if (w_wr_en && w_pxl) r_bank_st[w_cur_bank] <= B_PENDING;

            if (w_pq_pop) begin
                r_pq_ph[0]   <= r_pq_ph[1];
                r_pq_bank[0] <= r_pq_bank[1];
                r_pq_ph[1]   <= r_pq_ph[2];
                r_pq_bank[1] <= r_pq_bank[2];
            end
            if (w_pq_push) begin
                r_pq_ph[w_pq_widx]   <= w_cur_drop;
                r_pq_bank[w_pq_widx] <= w_cur_bank;
            end
            r_pq_cnt <= r_pq_cnt + {1'b0, w_pq_push} - {1'b0, w_pq_pop};

            if (w_done) r_dq_bank[0] <= r_dq_bank[1];
            if (w_dec_real) r_dq_bank[w_dq_widx] <= w_dec_bank;
            r_dq_cnt <= r_dq_cnt + {1'b0, w_dec_real} - {1'b0, w_done};

            case (r_rd_st)
                RD_PRIME: begin
                    r_rd_dat   <= r_mem[w_drain_bank][0];
                    r_beat     <= '0;
                    r_rd_route <= r_bank_route[w_drain_bank];
                end
                RD_STREAM: begin
                    if (w_hs && !w_last) begin
                        r_rd_dat <= r_mem[w_drain_bank][w_beat_nxt];
                        r_beat   <= w_beat_nxt;
                    end
                end
                default: ;
            endcase

            if (w_done) begin
                if (r_rd_route) r_cnn_cnt <= r_cnn_cnt + 1'b1;
                else            r_snn_cnt <= r_snn_cnt + 1'b1;
            end
        end
    end

    assign bus.oCnnValid = w_out_vld && r_rd_route;
    assign bus.oSnnValid = w_out_vld && !r_rd_route;
    assign bus.oCnnData  = bus.oCnnValid ? r_rd_dat : '0;
    assign bus.oSnnData  = bus.oSnnValid ? r_rd_dat : '0;
    assign bus.oCnnLast  = bus.oCnnValid && w_last;
    assign bus.oSnnLast  = bus.oSnnValid && w_last;

    assign oCnnTiles = r_cnn_cnt;
    assign oSnnTiles = r_snn_cnt;
    assign oOverflow = r_ovf;
    assign oProtoErr = r_proto;
endmodule

// File: tb/tb_tile_dispatcher.sv
// Randomised and directed stimulus for tile_dispatcher, checked every cycle against a tile-level queue model.
module tb_tile_dispatcher;
    localparam int TP = 256;

    logic        iClk;
    logic        iRst;
    logic [15:0] cnn_tiles;
    logic [15:0] snn_tiles;
    logic        ovf;
    logic        proto;

    tile_dispatcher_if #(.PIX_W(8)) bus();

    tile_dispatcher #(.TILE_WIDTH(16), .PIX_W(8), .CNT_W(16)) dut (
        .iClk      (iClk),
        .iRst      (iRst),
        .bus       (bus),
        .oCnnTiles (cnn_tiles),
        .oSnnTiles (snn_tiles),
        .oOverflow (ovf),
        .oProtoErr (proto)
    );

    initial begin
        iClk = 1'b0;
        forever #5 iClk = ~iClk;
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: tiles as whole objects moving through queues.
    typedef struct {
        bit              ph;
        bit              route;
        logic [TP*8-1:0] px;
    } tile_t;

    tile_t           pq[$];
    tile_t           rq[$];
    logic [TP*8-1:0] cur_px;
    bit              cur_drop;
    int              widx;
    int              occ;
    int              rbeat;
    logic [15:0]     m_cnn;
    logic [15:0]     m_snn;
    bit              m_ovf;
    bit              m_proto;
    bit              mon_en = 1'b0;

    always @(negedge iClk) begin : monitor
        tile_t t;
        bit done;
        bit hs;
        logic [7:0] d_sel;
        bit l_sel;
        if (mon_en) begin
            done = 1'b0;
            chk("cnn_tiles", cnn_tiles, m_cnn);
            chk("snn_tiles", snn_tiles, m_snn);
            chk("overflow", ovf, m_ovf);
            chk("proto_err", proto, m_proto);
            if (!bus.oCnnValid) begin
                chk("cnn_idle_data", bus.oCnnData, 0);
                chk("cnn_idle_last", bus.oCnnLast, 0);
            end
            if (!bus.oSnnValid) begin
                chk("snn_idle_data", bus.oSnnData, 0);
                chk("snn_idle_last", bus.oSnnLast, 0);
            end
            if (bus.oCnnValid || bus.oSnnValid) begin
                if (rq.size() == 0) begin
                    chk("valid_without_decided_tile", 1, 0);
                end else begin
                    chk("cnn_valid_path", bus.oCnnValid, rq[0].route);
                    chk("snn_valid_path", bus.oSnnValid, !rq[0].route);
                    d_sel = rq[0].route ? bus.oCnnData : bus.oSnnData;
                    l_sel = rq[0].route ? bus.oCnnLast : bus.oSnnLast;
                    chk("beat_data", d_sel, rq[0].px[rbeat*8 +: 8]);
                    chk("beat_last", l_sel, (rbeat == TP-1));
                    hs = rq[0].route ? (bus.oCnnValid && bus.iCnnReady)
                                     : (bus.oSnnValid && bus.iSnnReady);
                    if (hs) begin
                        if (rbeat == TP-1) begin
                            t = rq.pop_front();
                            if (t.route) m_cnn = m_cnn + 16'd1;
                            else         m_snn = m_snn + 16'd1;
                            rbeat = 0;
                            done  = 1'b1;
                        end else begin
                            rbeat++;
                        end
                    end
                end
            end
        end
        if (!iRst) begin
            pq.delete();
            rq.delete();
            widx = 0; occ = 0; rbeat = 0; cur_drop = 1'b0;
            m_cnn = '0; m_snn = '0; m_ovf = 1'b0; m_proto = 1'b0;
        end else begin
            if (done) occ--;
            if (bus.iDecisionValid) begin
                if (pq.size() == 0) begin
                    m_proto = 1'b1;
                end else begin
                    t = pq.pop_front();
                    if (!t.ph) begin
                        t.route = bus.iRouteToCnn;
                        rq.push_back(t);
                    end
                end
            end
            if (bus.iValid) begin
                if (widx == 0) begin
                    if (occ < 2) begin
                        occ++;
                        cur_drop = 1'b0;
                    end else begin
                        cur_drop = 1'b1;
                        m_ovf    = 1'b1;
                    end
                end
                cur_px[widx*8 +: 8] = bus.iData;
                if (widx == TP-1) begin
                    if (pq.size() < 3) begin
                        t.ph = cur_drop; t.route = 1'b0; t.px = cur_px;
                        pq.push_back(t);
                    end
                    widx = 0;
                end else begin
                    widx++;
                end
            end
        end
    end

    // Sink ready patterns: 0 both high, 1 CNN 1,0,0,1, 2 CNN stalled, 3 random.
    int rdy_mode = 0;
    int rcyc = 0;
    initial begin
        bus.iCnnReady = 1'b0;
        bus.iSnnReady = 1'b0;
        forever begin
            @(posedge iClk);
            #1;
            case (rdy_mode)
                0: begin bus.iCnnReady = 1'b1; bus.iSnnReady = 1'b1; end
                1: begin bus.iCnnReady = (rcyc % 4 == 0) || (rcyc % 4 == 3); bus.iSnnReady = 1'b1; end
                2: begin bus.iCnnReady = 1'b0; bus.iSnnReady = 1'b1; end
                default: begin
                    bus.iCnnReady = 1'($urandom_range(0, 1));
                    bus.iSnnReady = 1'($urandom_range(0, 1));
                end
            endcase
            rcyc++;
        end
    end

    task automatic step();
        @(posedge iClk);
        #1;
    endtask

    task automatic send_tile(input int mode, input bit dec_first, input bit route, input int gap);
        for (int i = 0; i < TP; i++) begin
            bus.iValid         = 1'b1;
            bus.iData          = (mode == 0) ? 8'(i) : 8'($urandom_range(0, 255));
            bus.iDecisionValid = dec_first && (i == 0);
            bus.iRouteToCnn    = route;
            step();
        end
        bus.iValid         = 1'b0;
        bus.iDecisionValid = 1'b0;
        repeat (gap) step();
    endtask

    task automatic decide(input bit route);
        bus.iDecisionValid = 1'b1;
        bus.iRouteToCnn    = route;
        step();
        bus.iDecisionValid = 1'b0;
    endtask

    task automatic wait_drain(input string nm, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (pq.size() == 0 && rq.size() == 0) break;
            step();
        end
        step();
        chk(nm, (pq.size() == 0 && rq.size() == 0), 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no completion, required finish before 2 ms");
        $fatal(1);
    end

    initial begin : stim
        int lat;
        logic [15:0] c0;
        logic [15:0] s0;
        int drv_idx;
        int drv_undec;
        iRst = 1'b0;
        bus.iValid = 1'b0;
        bus.iData = '0;
        bus.iDecisionValid = 1'b0;
        bus.iRouteToCnn = 1'b0;
        step();
        mon_en = 1'b1;
        chk("reset_cnn_valid", bus.oCnnValid, 0);
        chk("reset_snn_valid", bus.oSnnValid, 0);
        step();
        iRst = 1'b1;
        step();

        // Single ramp tile to CNN, decision one cycle after the last pixel.
        send_tile(0, 1'b0, 1'b0, 0);
        bus.iDecisionValid = 1'b1;
        bus.iRouteToCnn    = 1'b1;
        step();
        bus.iDecisionValid = 1'b0;
        lat = 0;
        for (int i = 1; i <= 8; i++) begin
            step();
            if (bus.oCnnValid) begin
                lat = i;
                break;
            end
        end
        chk("first_beat_latency", lat, 2);
        chk("first_beat_value", bus.oCnnData, 0);
        wait_drain("drain_single", 600);
        chk("single_cnn_tiles", cnn_tiles, 1);
        chk("single_snn_tiles", snn_tiles, 0);

        // Four tiles, routes 0,1,0,1; each decision lands with the next tile's pixel 0.
        c0 = cnn_tiles; s0 = snn_tiles;
        send_tile(1, 1'b0, 1'b0, 4);
        send_tile(1, 1'b1, 1'b0, 4);
        send_tile(1, 1'b1, 1'b1, 4);
        send_tile(1, 1'b1, 1'b0, 4);
        decide(1'b1);
        wait_drain("drain_alt", 1500);
        chk("alt_cnn_tiles", cnn_tiles - c0, 2);
        chk("alt_snn_tiles", snn_tiles - s0, 2);
        chk("alt_overflow", ovf, 0);
        chk("alt_proto", proto, 0);

        // CNN backpressure 1,0,0,1.
        rdy_mode = 1;
        c0 = cnn_tiles;
        send_tile(1, 1'b0, 1'b0, 0);
        decide(1'b1);
        wait_drain("drain_bp", 1500);
        chk("bp_cnn_tiles", cnn_tiles - c0, 1);

        // Overflow: CNN stalled, three tiles back to back, the third is dropped.
        rdy_mode = 2;
        c0 = cnn_tiles;
        send_tile(1, 1'b0, 1'b0, 0);
        send_tile(1, 1'b1, 1'b1, 0);
        send_tile(1, 1'b1, 1'b1, 0);
        decide(1'b1);
        repeat (3) step();
        chk("ovf_flag", ovf, 1);
        chk("ovf_no_proto", proto, 0);
        chk("ovf_stalled_count", cnn_tiles - c0, 0);
        rdy_mode = 0;
        wait_drain("drain_ovf", 1500);
        chk("ovf_cnn_tiles", cnn_tiles - c0, 2);
        chk("ovf_proto_after", proto, 0);

        // Spurious decision with nothing pending.
        decide(1'b0);
        step();
        chk("spurious_proto", proto, 1);
        s0 = snn_tiles;
        send_tile(1, 1'b0, 1'b0, 0);
        decide(1'b0);
        wait_drain("drain_spur", 600);
        chk("spur_snn_tiles", snn_tiles - s0, 1);
        chk("spur_proto_sticky", proto, 1);

        // Reset at beat 100 of a CNN ramp tile.
        send_tile(0, 1'b0, 1'b0, 0);
        decide(1'b1);
        for (int i = 0; i < 600; i++) begin
            if (bus.oCnnValid && bus.oCnnData == 8'd100) break;
            step();
        end
        chk("beat100_reached", (bus.oCnnValid && bus.oCnnData == 8'd100), 1);
        iRst = 1'b0;
        step();
        chk("rst_cnn_valid", bus.oCnnValid, 0);
        chk("rst_cnn_data", bus.oCnnData, 0);
        chk("rst_snn_valid", bus.oSnnValid, 0);
        chk("rst_cnn_tiles", cnn_tiles, 0);
        chk("rst_snn_tiles", snn_tiles, 0);
        chk("rst_proto", proto, 0);
        chk("rst_overflow", ovf, 0);
        iRst = 1'b1;
        step();
        send_tile(0, 1'b0, 1'b0, 0);
        decide(1'b1);
        wait_drain("drain_after_rst", 600);
        chk("post_rst_cnn_tiles", cnn_tiles, 1);

        // Random traffic, random readies, random decision timing.
        rdy_mode = 3;
        drv_idx = 0;
        drv_undec = 0;
        for (int c = 0; c < 6000; c++) begin
            bus.iValid         = ($urandom_range(0, 3) != 0);
            bus.iData          = 8'($urandom_range(0, 255));
            bus.iDecisionValid = (drv_undec > 0) && ($urandom_range(0, 5) == 0);
            bus.iRouteToCnn    = 1'($urandom_range(0, 1));
            if (bus.iDecisionValid) drv_undec--;
            if (bus.iValid) begin
                if (drv_idx == TP-1) begin
                    drv_idx = 0;
                    if (drv_undec < 3) drv_undec++;
                end else begin
                    drv_idx++;
                end
            end
            step();
        end
        bus.iValid = 1'b0;
        while (drv_undec > 0) begin
            decide(1'($urandom_range(0, 1)));
            drv_undec--;
        end
        wait_drain("drain_random", 4000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
